// File: rtl/range_frame_gen_if.sv
// Sample-in / frame-out bundle for range_frame_gen.
// Latency: none, this is only wiring.
// Backpressure: in_ready is driven by the slave, and the frame side has no ready signal.
//
// Signals:
//   in_data/in_valid/in_last/in_ready : producer stream (valid/ready handshake)
//   data_out/go/finish/busy/drop       : frame protocol toward the range-finding stage
interface range_frame_gen_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic             busy;
  logic             drop;

  // Producer / testbench side.
  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, data_out, go, finish, busy, drop
  );

  // Block side.
  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, data_out, go, finish, busy, drop
  );
endinterface

// File: rtl/range_frame_gen.sv
// Buffers whole frames from a valid/ready sample stream and replays each one as a gap-free go/data/finish burst.
// Latency: go appears one edge after the frame's last word is accepted if the reader is idle; one idle cycle separates frames.
// Backpressure: in_ready drops while the FIFO is full of held words; oversize frames are discarded and flagged with drop.
//
// Ports:
//   clock, reset (async, active low)
//   bus.slave : in_data/in_valid/in_last/in_ready in, data_out/go/finish/busy/drop out
module range_frame_gen #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  range_frame_gen_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, EMIT} state_t;

  // Each entry holds {last flag, sample}.
  logic [WIDTH:0]  mem [DEPTH];

  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   start_ptr;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   cur_len;
  logic [CW-1:0]   frames_pending;
  logic            discarding;
  state_t          state;

  logic [WIDTH-1:0] data_q;
  logic            go_q;
  logic            finish_q;
  logic            busy_q;
  logic            drop_q;

  logic            in_ready_i;
  logic            accept;
  logic            oversize;
  logic            wr_en;
  logic            rd_en;
  logic            rd_start;
  logic [WIDTH:0]  head;

  // A partial frame that has reached DEPTH must keep accepting so the
  // overflowing word can be seen and the frame rolled back. Otherwise a
  // full FIFO is plain backpressure. Held low while reset is asserted.
  assign in_ready_i = reset & (discarding |
                               (cur_len == CW'(DEPTH)) |
                               (fifo_count < CW'(DEPTH)));

  assign accept   = bus.in_valid & in_ready_i;
  assign oversize = accept & ~discarding & (cur_len == CW'(DEPTH));
  assign wr_en    = accept & ~discarding & ~oversize;

  // Reads happen on the go edge and on every EMIT edge until the last word
  // has been shown. The edge after finish is a deliberate idle gap.
  assign rd_start = (state == IDLE) && (frames_pending != '0);
  assign rd_en    = rd_start || ((state == EMIT) && !finish_q);
  assign head     = mem[rptr];

  assign bus.in_ready = in_ready_i;
  assign bus.data_out = data_q;
  assign bus.go       = go_q;
  assign bus.finish   = finish_q;
  assign bus.busy     = busy_q;
  assign bus.drop     = drop_q;

  // Storage array, left unreset: validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wptr] <= {bus.in_last, bus.in_data};
    end
  end

  // Write side: partial-frame tracking, rollback and discard.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr       <= '0;
      start_ptr  <= '0;
      cur_len    <= '0;
      discarding <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (accept) begin
        if (discarding) begin
          if (bus.in_last) begin
            discarding <= 1'b0;
            drop_q     <= 1'b1;
          end
        end else if (oversize) begin
          // Free the partial words. start_ptr sits just past the newest
          // complete frame, so complete frames are never disturbed.
          wptr    <= start_ptr;
          cur_len <= '0;
          if (bus.in_last) begin
            drop_q <= 1'b1;
          end else begin
            discarding <= 1'b1;
          end
        end else begin
          wptr <= wptr + AW'(1);
          if (bus.in_last) begin
            cur_len   <= '0;
            start_ptr <= wptr + AW'(1);
          end else begin
            cur_len <= cur_len + CW'(1);
          end
        end
      end
    end
  end

  // Occupancy and frame counters, which both the write side and the read side update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fifo_count     <= '0;
      frames_pending <= '0;
    end else begin
      fifo_count     <= fifo_count + CW'(wr_en) - CW'(rd_en)
                        - (oversize ? cur_len : '0);
      frames_pending <= frames_pending + CW'(wr_en & bus.in_last)
                        - CW'(rd_start);
    end
  end

  // Read FSM with registered frame outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rptr     <= '0;
      data_q   <= '0;
      go_q     <= 1'b0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_start) begin
            rptr     <= rptr + AW'(1);
            data_q   <= head[WIDTH-1:0];
            go_q     <= 1'b1;
            busy_q   <= 1'b1;
            finish_q <= head[WIDTH];
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (finish_q) begin
            data_q   <= '0;
            go_q     <= 1'b0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else begin
            rptr     <= rptr + AW'(1);
            data_q   <= head[WIDTH-1:0];
            go_q     <= 1'b0;
            finish_q <= head[WIDTH];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_frame_gen.sv
module tb_range_frame_gen;

  logic clock;
  logic reset;

  range_frame_gen_if #(.WIDTH(16)) bus ();

  range_frame_gen #(.WIDTH(16), .DEPTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // One table row: inputs for the coming edge and the outputs expected
  // at the negedge before it, packed as {go,finish,busy,drop,in_ready,data_out}.
  typedef struct {
    logic        v;
    logic        l;
    logic [15:0] d;
    logic [20:0] e;
  } vec_t;

  vec_t vecs[$];

  logic        mon_en = 1'b0;
  logic [17:0] em_q[$];

  always @(negedge clock) begin
    if (mon_en && bus.busy) em_q.push_back({bus.go, bus.finish, bus.data_out});
  end

  function automatic logic [31:0] outs();
    return {11'd0, bus.go, bus.finish, bus.busy, bus.drop, bus.in_ready, bus.data_out};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic add(input int v, input int l, input int d, input int go, input int fin,
                     input int busy, input int drop, input int rdy, input int dat);
    vec_t r;
    r.v = (v != 0);
    r.l = (l != 0);
    r.d = 16'(d);
    r.e = {go != 0, fin != 0, busy != 0, drop != 0, rdy != 0, 16'(dat)};
    vecs.push_back(r);
  endtask

  // Word offered, reader idle, in_ready high.
  task automatic row_in(input int d, input int l);
    add(1, l, d, 0, 0, 0, 0, 1, 0);
  endtask

  // Nothing offered, reader idle.
  task automatic row_idle();
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  // Nothing offered, reader emitting.
  task automatic row_out(input int go, input int fin, input int dat);
    add(0, 0, 0, go, fin, 1, 0, 1, dat);
  endtask

  // Offer one word and hold it until an edge accepts it (bounded).
  task automatic send_word(input int d, input bit l);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(d);
    bus.in_last  = l;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clock);
      if (bus.in_ready) done = 1'b1;
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %0d never accepted", d);
    end
  endtask

  initial begin
    int          bc;
    bit          seen;
    logic [17:0] got18;
    logic [17:0] exp18;

    // Frame 3,9,5
    row_in(3, 0); row_in(9, 0); row_in(5, 1); row_idle();
    row_out(1, 0, 3); row_out(0, 0, 9); row_out(0, 1, 5); row_idle();
    // Single-word frame
    row_in(42, 1); row_idle(); row_out(1, 1, 42); row_idle();
    // Back-to-back frames {7,8} {20,21}
    row_in(7, 0); row_in(8, 1); row_in(20, 0);
    add(1, 1, 21, 1, 0, 1, 0, 1, 7);
    row_out(0, 1, 8); row_idle(); row_out(1, 0, 20); row_out(0, 1, 21); row_idle();
    // 8-word frame with gaps: FIFO full once complete
    row_in(1, 0); row_idle(); row_in(2, 0); row_in(3, 0); row_idle();
    row_in(4, 0); row_in(5, 0); row_in(6, 0); row_idle(); row_in(7, 0); row_in(8, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    row_out(1, 0, 1);
    for (int k = 2; k <= 7; k++) row_out(0, 0, k);
    row_out(0, 1, 8); row_idle();
    // 9-word frame, last on the ninth word
    for (int k = 0; k < 8; k++) row_in(100 + k, 0);
    row_in(108, 1);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0);
    row_idle(); row_idle();
    // 10-word frame: discard mode after the ninth word
    for (int k = 0; k < 8; k++) row_in(200 + k, 0);
    row_in(208, 0); row_idle(); row_in(209, 1);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0);
    row_idle(); row_idle();

    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clock);
    chk("reset_state", outs(), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.in_valid = vecs[i].v;
      bus.in_last  = vecs[i].l;
      bus.in_data  = vecs[i].d;
      @(negedge clock);
      chk($sformatf("vec%0d", i), outs(), {11'd0, vecs[i].e});
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;

    // Full FIFO then eight 1-word frames queued behind a long frame
    em_q.delete();
    mon_en = 1'b1;
    for (int k = 0; k < 8; k++) send_word(50 + k, k == 7);
    @(negedge clock);
    chk("full_rdy", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("rdy_after_read", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clock);
    #1;
    for (int k = 0; k < 8; k++) send_word(60 + k, 1'b1);
    for (int t = 0; t < 100 && em_q.size() < 16; t++) @(posedge clock);
    repeat (5) @(posedge clock);
    #1;
    mon_en = 1'b0;
    chk("emit_count", 32'(em_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < 8) exp18 = {i == 0, i == 7, 16'(50 + i)};
      else       exp18 = {1'b1, 1'b1, 16'(60 + i - 8)};
      got18 = (i < em_q.size()) ? em_q[i] : 18'h3ffff;
      chk($sformatf("emit%0d", i), {14'd0, got18}, {14'd0, exp18});
    end

    // Reset in the middle of emitting 10,11,12,13
    for (int k = 0; k < 4; k++) send_word(10 + k, k == 3);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clock);
      if (bus.go) seen = 1'b1;
    end
    chk("mid_go_seen", {31'd0, seen}, 32'd1);
    chk("mid_go_data", {16'd0, bus.data_out}, 32'd10);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_reset_outputs", outs(), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #3;
    reset = 1'b1;
    bc = 0;
    repeat (10) begin
      @(negedge clock);
      if (bus.busy || bus.go || bus.finish) bc++;
    end
    chk("no_emit_after_reset", 32'(bc), 32'd0);
    @(posedge clock);
    #1;
    send_word(5, 1'b1);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clock);
      if (bus.go) seen = 1'b1;
    end
    chk("post_reset_frame", {13'd0, bus.go, bus.finish, bus.busy, bus.data_out},
        {13'd0, 1'b1, 1'b1, 1'b1, 16'd5});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/range_frame_gen.md
Name: range_frame_gen

Overview:
- Upstream feeder for the range-finding stage; converts a bursty valid/ready sample stream into the contiguous go/data/finish frame protocol that stage consumes.
- Frames are delimited by `in_last` and buffered in an internal FIFO.
- A frame is emitted only once it has been received completely, so the consumer sees one sample per cycle with no gaps.
- Frames longer than the buffer are discarded and flagged.

Parameters:
- WIDTH, 16, sample width in bits.
- DEPTH, 8, FIFO depth in words and maximum frame length; power of 2, at least 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- in_data  input  WIDTH  incoming sample.
- in_valid  input  1  in_data/in_last valid.
- in_last  input  1  final sample of the current frame.
- in_ready  output  1  block accepts a word this cycle.
- data_out  output  WIDTH  sample presented to the consumer.
- go  output  1  first sample of a frame.
- finish  output  1  last sample of a frame.
- busy  output  1  frame emission in progress, from go through finish inclusive.
- drop  output  1  one-cycle pulse: an oversize frame was discarded.

Behaviour:
- Reset:
  - While reset=0: FIFO empty, counters zero, state IDLE.
  - data_out=0, go=0, finish=0, busy=0, drop=0, in_ready=0.
  - Reset mid-frame, on either the write or read side, abandons all buffered data. Nothing is emitted afterwards for that frame.
- Accept:
  - A word is accepted on a rising edge where in_valid and in_ready are both 1.
  - FIFO entries are WIDTH+1 bits wide: the sample plus its last flag.
- in_ready (combinational from registered state; no same-cycle pass-through of read-side frees):
  - in_ready = discarding OR (cur_len == DEPTH) OR (fifo_count < DEPTH).
- Write side:
  - cur_len counts the words of the partial frame held in the FIFO.
  - A partial frame may exceed neither DEPTH nor the free space; lack of space is plain backpressure.
  - When a word with in_last is accepted and stored: frames_pending increments, cur_len returns to 0, and the frame-start pointer moves to the write pointer.
- Oversize frame:
  - Occurs when a word is accepted while cur_len == DEPTH.
  - That word is not stored. The write pointer rolls back to the frame-start pointer, so the partial words are freed, and cur_len returns to 0.
  - If that word has in_last: drop pulses on the next cycle.
  - Otherwise the block enters DISCARD: in_ready=1 and every word is thrown away until an accepted in_last word, then it returns to normal. drop pulses on the cycle after that in_last word is accepted.
  - A frame of exactly DEPTH words is valid and is emitted.
- Read side, FSM IDLE / EMIT (all outputs registered):
  - IDLE: if frames_pending > 0, the next edge loads the head word and enters EMIT. That cycle shows go=1, busy=1, data_out=word, and frames_pending decrements.
  - EMIT: one word per edge. finish=1 in the cycle whose word carries the last flag, after which the FSM returns to IDLE.
  - A single-word frame shows go=1 and finish=1 in the same cycle.
  - At least one idle cycle always separates finish from the next go.
  - When not emitting, data_out=0.
- Latency:
  - If the frame's last word is accepted at edge E0 and the FSM is IDLE after E0, go is visible after edge E1.
  - Steady state: frame length plus one cycle per frame.
- Simultaneous events:
  - A frame completing on the same edge as an emission start leaves frames_pending unchanged (+1 −1).
  - FIFO read and write on the same edge leave fifo_count unchanged.
  - The write pointer rollback never touches words belonging to complete frames.
- Pointers and counts:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - fifo_count and cur_len are log2(DEPTH)+1 bits.
  - frames_pending is log2(DEPTH)+1 bits and never exceeds DEPTH.

Test Plan:
- Frame 3, 9, 5 (last on 5), in_valid continuous, DEPTH=8 → go appears one cycle after acceptance of 5. Then data_out is 3 (go), 9, 5 (finish) on consecutive cycles, with busy=1 across all three.
- Single-word frame 42 with in_last → one cycle with go=1, finish=1, data_out=42; busy high for exactly that cycle.
- 8-word frame 1..8 with random in_valid gaps → emitted contiguously 1..8 after the last word. A 9-word frame then yields no go, drop=1 for one cycle after its last word, and in_ready=1 throughout the discard.
- Frames {7, 8} and {20, 21} sent back-to-back → sequence go/7, finish/8, one idle cycle with data_out=0, then go/20, finish/21.
- Eight 1-word frames sent while the read side is held in EMIT by a long prior frame → in_ready=0 when fifo_count=8, and it returns to 1 the cycle after the first read. No word is lost or reordered.
- reset=0 asserted midway through emitting frame 10, 11, 12, 13 → go, finish, busy and data_out go to 0 immediately. No further emission after release; the next frame 5 emits normally.
